// File: rtl/reg_scoreboard_pkg.sv
// Shared definitions for the register scoreboard: register-file geometry and
// the decode/writeback sideband layouts that feed it.
package reg_scoreboard_pkg;

   localparam int REG_AW  = 5;
   localparam int REG_NUM = 32;

   typedef struct packed {
      logic              ds_valid;
      logic              ds_issue;
      logic              rs_used;
      logic [REG_AW-1:0] rs;
      logic              rt_used;
      logic [REG_AW-1:0] rt;
      logic [REG_AW-1:0] dest;
   } ds_to_sb_bus_t;

   typedef struct packed {
      logic              retire;
      logic [REG_AW-1:0] dest;
   } ws_to_sb_bus_t;

   function automatic logic reg_nz(input logic [REG_AW-1:0] a);
      return a != '0;
   endfunction

endpackage

// File: rtl/reg_scoreboard_sb_counter.sv
// Saturating in-flight write counter for one architectural register.
// up/down report the increments/decrements that actually take effect.
module sb_counter #(
   parameter int CNT_W = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic inc,
   input  logic dec,
   output logic zero,
   output logic full,
   output logic up,
   output logic down,
   output logic underflow
);

   logic [CNT_W-1:0] cnt;

   assign zero = (cnt == '0);
   assign full = &cnt;

   // Simultaneous inc and dec cancel, so neither saturation nor underflow applies.
   assign up        = inc & ~dec & ~full & ~clr;
   assign down      = dec & ~inc & ~zero & ~clr;
   assign underflow = dec & ~inc &  zero & ~clr;

   always_ff @(posedge clk) begin
      if (reset || clr)
         cnt <= '0;
      else if (up)
         cnt <= cnt + 1'b1;
      else if (down)
         cnt <= cnt - 1'b1;
   end

endmodule

// File: rtl/reg_scoreboard.sv
// Per-register in-flight write scoreboard sitting beside decode; produces the
// operand/destination stalls that gate decode's ready_go.
module reg_scoreboard
   import reg_scoreboard_pkg::*;
#(
   parameter int NREG  = REG_NUM,
   parameter int CNT_W = 2,
   parameter int AW    = REG_AW
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             ds_valid,
   input  logic [AW-1:0]    ds_rs,
   input  logic             ds_rs_used,
   input  logic [AW-1:0]    ds_rt,
   input  logic             ds_rt_used,
   input  logic [AW-1:0]    ds_dest,
   input  logic             ds_issue,
   input  logic             ws_retire,
   input  logic [AW-1:0]    ws_dest,
   input  logic             flush,
   output logic             rs_stall,
   output logic             rt_stall,
   output logic             dest_full,
   output logic             ds_stall,
   output logic [CNT_W+2:0] inflight,
   output logic             err_underflow
);

   localparam int IW = CNT_W + 3;

   ds_to_sb_bus_t ds;
   ws_to_sb_bus_t ws;

   assign ds.ds_valid = ds_valid;
   assign ds.ds_issue = ds_issue;
   assign ds.rs_used  = ds_rs_used;
   assign ds.rs       = ds_rs;
   assign ds.rt_used  = ds_rt_used;
   assign ds.rt       = ds_rt;
   assign ds.dest     = ds_dest;
   assign ws.retire   = ws_retire;
   assign ws.dest     = ws_dest;

   logic [NREG-1:0] zero, full, up, down, uf;

   // Register 0 is hardwired: never pending, never full, never counted.
   assign zero[0] = 1'b1;
   assign full[0] = 1'b0;
   assign up[0]   = 1'b0;
   assign down[0] = 1'b0;
   assign uf[0]   = 1'b0;

   for (genvar r = 1; r < NREG; r++) begin : g_cnt
      sb_counter #(.CNT_W(CNT_W)) u_cnt (
         .clk      (clk),
         .reset    (reset),
         .clr      (flush),
         .inc      (ds.ds_issue && ds.dest == AW'(r)),
         .dec      (ws.retire   && ws.dest == AW'(r)),
         .zero     (zero[r]),
         .full     (full[r]),
         .up       (up[r]),
         .down     (down[r]),
         .underflow(uf[r])
      );
   end

   // No bypass: a consumer stays stalled in the retire cycle itself.
   assign rs_stall  = ds.rs_used && reg_nz(ds.rs) && !zero[ds.rs];
   assign rt_stall  = ds.rt_used && reg_nz(ds.rt) && !zero[ds.rt];
   assign dest_full = reg_nz(ds.dest) && full[ds.dest];
   assign ds_stall  = ds.ds_valid && (rs_stall || rt_stall || dest_full);

   // At most one counter moves each way per cycle, so the sum moves by +-1.
   always_ff @(posedge clk) begin
      if (reset || flush)
         inflight <= '0;
      else
         inflight <= inflight + IW'(|up) - IW'(|down);
   end

   always_ff @(posedge clk) begin
      if (reset)
         err_underflow <= 1'b0;
      else if (|uf)
         err_underflow <= 1'b1;
   end

endmodule
